// File: rtl/first_nios2_system_sysid_checker.sv
// first_nios2_system_sysid_checker
//
// Purpose:
//   Avalon-MM read master that sits directly in front of the system-ID slave.
//   After reset (AUTO_START=1) or on a start pulse, it reads the ID word
//   (address 0) and then the timestamp word (address 1). It compares them
//   against build-time constants and reports pass/fail/done status. This
//   catches a mismatched .sof/.elf pair before software starts running.
//
// Optional feature (macro SYSID_CHECK_TIMESTAMP_EN):
//   defined     - the timestamp is compared against EXPECTED_TIMESTAMP, and a
//                 mismatch reports err_code 2.
//   not defined - the timestamp is read and captured but never compared.
//
// Ports:
//   clock              in   1   system clock
//   reset              in   1   synchronous, active-high reset
//   start              in   1   single-cycle pulse; starts a check when idle or done
//   avm_address        out  1   slave word address (0 = ID, 1 = timestamp)
//   avm_read           out  1   read request
//   avm_waitrequest    in   1   slave stall; the request is held while high
//   avm_readdatavalid  in   1   read data valid strobe
//   avm_readdata       in   32  slave read data
//   id_value           out  32  captured ID word
//   ts_value           out  32  captured timestamp word
//   busy               out  1   check in progress
//   done               out  1   check finished; held until the next start or reset
//   pass               out  1   done and every compare matched
//   err_code           out  2   0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5AAA_F307,
    parameter int unsigned TIMEOUT_CYCLES     = 256,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code
);

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS_CHECK_EN = 1'b1;
`else
    localparam bit TS_CHECK_EN = 1'b0;
`endif

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_ID,
        S_WAIT_ID,
        S_REQ_TS,
        S_WAIT_TS,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] timer;
    logic        timeout_hit;
    logic        capture_id;
    logic        capture_ts;
    logic        timer_clear;
    logic        clear_status;
    logic        timed_out;

    assign busy        = (state == S_REQ_ID) || (state == S_WAIT_ID) ||
                         (state == S_REQ_TS) || (state == S_WAIT_TS);
    assign done        = (state == S_DONE);
    assign pass        = done && (err_code == 2'd0);
    assign timeout_hit = busy && (timer == TIMEOUT_LAST);

    // On a timeout the request is withdrawn in that same cycle, so the slave
    // never accepts a read that the master has already given up on.
    assign avm_read    = ((state == S_REQ_ID) || (state == S_REQ_TS)) && !timeout_hit;
    assign avm_address = (state == S_REQ_TS);

    // Next-state logic. A readdatavalid in the cycle that accepts the request
    // is a zero-latency slave, so the data is captured and the WAIT state is skipped.
    // A timeout takes priority over acceptance and over arriving data.
    always_comb begin
        state_next   = state;
        capture_id   = 1'b0;
        capture_ts   = 1'b0;
        timer_clear  = 1'b0;
        clear_status = 1'b0;
        timed_out    = 1'b0;
        case (state)
            S_IDLE: begin
                if (AUTO_START || start) begin
                    state_next  = S_REQ_ID;
                    timer_clear = 1'b1;
                end
            end
            S_REQ_ID: begin
                if (timeout_hit) begin
                    state_next = S_DONE;
                    timed_out  = 1'b1;
                end else if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        capture_id  = 1'b1;
                        state_next  = S_REQ_TS;
                        timer_clear = 1'b1;
                    end else begin
                        state_next = S_WAIT_ID;
                    end
                end
            end
            S_WAIT_ID: begin
                if (timeout_hit) begin
                    state_next = S_DONE;
                    timed_out  = 1'b1;
                end else if (avm_readdatavalid) begin
                    capture_id  = 1'b1;
                    state_next  = S_REQ_TS;
                    timer_clear = 1'b1;
                end
            end
            S_REQ_TS: begin
                if (timeout_hit) begin
                    state_next = S_DONE;
                    timed_out  = 1'b1;
                end else if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        capture_ts = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_WAIT_TS;
                    end
                end
            end
            S_WAIT_TS: begin
                if (timeout_hit) begin
                    state_next = S_DONE;
                    timed_out  = 1'b1;
                end else if (avm_readdatavalid) begin
                    capture_ts = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next   = S_REQ_ID;
                    timer_clear  = 1'b1;
                    clear_status = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Only the first error is kept. A timeout on the timestamp read after an ID
    // mismatch therefore still reports the ID mismatch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= 16'd0;
            id_value <= 32'd0;
            ts_value <= 32'd0;
            err_code <= 2'd0;
        end else begin
            state <= state_next;

            if (timer_clear) begin
                timer <= 16'd0;
            end else if (busy) begin
                timer <= timer + 16'd1;
            end

            if (capture_id) begin
                id_value <= avm_readdata;
            end
            if (capture_ts) begin
                ts_value <= avm_readdata;
            end

            if (clear_status) begin
                err_code <= 2'd0;
            end else if (err_code == 2'd0) begin
                if (timed_out) begin
                    err_code <= 2'd3;
                end else if (capture_id && (avm_readdata != EXPECTED_ID)) begin
                    err_code <= 2'd1;
                end else if (capture_ts && TS_CHECK_EN &&
                             (avm_readdata != EXPECTED_TIMESTAMP)) begin
                    err_code <= 2'd2;
                end
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb_first_nios2_system_sysid_checker
//
// Purpose:
//   Directed bench for first_nios2_system_sysid_checker. A small Avalon slave
//   model has a configurable stall count, per-address read latency and return
//   data. A latency of -1 means "never respond". Expected values are hand-computed.
//   Build with or without SYSID_CHECK_TIMESTAMP_EN; the timestamp-mismatch
//   expectation follows that macro.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'h0000_0000;
    localparam logic [31:0] GOOD_TS = 32'h5AAA_F307;
    localparam logic [31:0] BAD_TS  = 32'h1234_5678;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;
    localparam int          BUDGET  = 60;

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam logic [1:0] TS_BAD_ERR  = 2'd2;
    localparam logic       TS_BAD_PASS = 1'b0;
`else
    localparam logic [1:0] TS_BAD_ERR  = 2'd0;
    localparam logic       TS_BAD_PASS = 1'b1;
`endif

    logic        clock             = 1'b0;
    logic        reset             = 1'b1;
    logic        start             = 1'b0;
    logic        avm_waitrequest   = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata      = 32'd0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  err_code;

    int vectors     = 0;
    int miscompares = 0;

    int          wait_cycles = 0;
    int          lat_id      = 1;
    int          lat_ts      = 1;
    logic [31:0] id_data     = GOOD_ID;
    logic [31:0] ts_data     = GOOD_TS;
    int          stall_cnt   = 0;
    int          pend_cnt    = 0;
    bit          pend        = 1'b0;
    logic [31:0] pend_data   = 32'd0;
    logic        prev_wr     = 1'b0;
    logic        prev_addr   = 1'b0;
    int          n;

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID        (GOOD_ID),
        .EXPECTED_TIMESTAMP (GOOD_TS),
        .TIMEOUT_CYCLES     (16),
        .AUTO_START         (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_code          (err_code)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int waits, input int lid, input int lts,
                                  input logic [31:0] idd, input logic [31:0] tsd);
        wait_cycles = waits;
        lat_id      = lid;
        lat_ts      = lts;
        id_data     = idd;
        ts_data     = tsd;
    endtask

    // Drives the slave responses for the current cycle from the DUT's
    // request outputs, which are stable by this point.
    task automatic slave_update();
        int          lat;
        logic [31:0] d;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        avm_waitrequest   = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend              = 1'b0;
                avm_readdatavalid = 1'b1;
                avm_readdata      = pend_data;
            end
        end
        if (avm_read) begin
            if (stall_cnt < wait_cycles) begin
                avm_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                stall_cnt = 0;
                lat = avm_address ? lat_ts : lat_id;
                d   = avm_address ? ts_data : id_data;
                if (lat == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = d;
                end else if (lat > 0) begin
                    pend      = 1'b1;
                    pend_cnt  = lat;
                    pend_data = d;
                end
            end
        end
    endtask

    // Advances one clock and lands 1 ns after the edge. Checks that a stalled
    // request was held stable across the edge.
    task automatic tick();
        prev_wr   = avm_waitrequest;
        prev_addr = avm_address;
        @(posedge clock);
        #1;
        if (prev_wr) begin
            check_output("stall_read_held", avm_read, 1'b1);
            check_output("stall_addr_held", avm_address, prev_addr);
        end
        slave_update();
    endtask

    task automatic run_to_done(input bit pulse, output int cycles);
        cycles = 0;
        if (pulse) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            cycles = 1;
        end
        while (!done && cycles < BUDGET) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_pass", pass, 1'b0);
        check_output("rst_err", err_code, 2'd0);
        check_output("rst_read", avm_read, 1'b0);
        check_output("rst_id", id_value, 32'd0);
        check_output("rst_ts", ts_value, 32'd0);
        reset = 1'b0;
        check_output("release_idle", busy, 1'b0);

        // 1: auto start, one-cycle slave, done five cycles after release
        apply_stimulus(0, 1, 1, GOOD_ID, GOOD_TS);
        run_to_done(1'b0, n);
        check_output("t1_latency", n, 5);
        check_output("t1_pass", pass, 1'b1);
        check_output("t1_err", err_code, 2'd0);
        check_output("t1_id", id_value, GOOD_ID);
        check_output("t1_ts", ts_value, GOOD_TS);
        check_output("t1_busy", busy, 1'b0);
        check_output("t1_read", avm_read, 1'b0);

        // 2: three stall cycles per read, data two cycles after accept
        apply_stimulus(3, 2, 2, GOOD_ID, GOOD_TS);
        run_to_done(1'b1, n);
        check_output("t2_latency", n, 13);
        check_output("t2_pass", pass, 1'b1);

        // start while busy is ignored
        apply_stimulus(0, 1, 1, GOOD_ID, GOOD_TS);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("busy_start_read", avm_read, 1'b1);
        check_output("busy_start_addr", avm_address, 1'b1);
        run_to_done(1'b0, n);
        check_output("busy_start_latency", n, 2);
        check_output("busy_start_pass", pass, 1'b1);

        // 3: ID mismatch; the timestamp is still read
        apply_stimulus(0, 1, 1, 32'h0000_0001, GOOD_TS);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t3_done_cleared", done, 1'b0);
        check_output("t3_busy", busy, 1'b1);
        check_output("t3_id_kept", id_value, GOOD_ID);
        run_to_done(1'b0, n);
        check_output("t3_latency", n, 4);
        check_output("t3_err", err_code, 2'd1);
        check_output("t3_pass", pass, 1'b0);
        check_output("t3_id", id_value, 32'h0000_0001);
        check_output("t3_ts", ts_value, GOOD_TS);

        // 4: timestamp mismatch; start clears the previous error
        apply_stimulus(0, 1, 1, GOOD_ID, BAD_TS);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t4_err_cleared", err_code, 2'd0);
        check_output("t4_pass_cleared", pass, 1'b0);
        check_output("t4_id_kept", id_value, 32'h0000_0001);
        run_to_done(1'b0, n);
        check_output("t4_err", err_code, TS_BAD_ERR);
        check_output("t4_pass", pass, TS_BAD_PASS);
        check_output("t4_ts", ts_value, BAD_TS);

        // both words wrong: the first error wins
        apply_stimulus(0, 1, 1, 32'h0000_0001, BAD_TS);
        run_to_done(1'b1, n);
        check_output("first_err_code", err_code, 2'd1);

        // 5: ID read never answered, timeout of 16 cycles
        apply_stimulus(0, -1, 1, GOOD_ID, GOOD_TS);
        run_to_done(1'b1, n);
        check_output("t5_latency", n, 17);
        check_output("t5_err", err_code, 2'd3);
        check_output("t5_pass", pass, 1'b0);
        check_output("t5_read", avm_read, 1'b0);
        check_output("t5_id_kept", id_value, 32'h0000_0001);
        check_output("t5_ts_kept", ts_value, BAD_TS);

        // timeout after an ID mismatch keeps the ID error
        apply_stimulus(0, 1, -1, 32'h0000_0001, GOOD_TS);
        run_to_done(1'b1, n);
        check_output("ts_timeout_latency", n, 19);
        check_output("ts_timeout_err", err_code, 2'd1);

        // spurious readdatavalid in DONE is ignored
        avm_readdatavalid = 1'b1;
        avm_readdata      = JUNK;
        tick();
        check_output("done_spurious_id", id_value, 32'h0000_0001);
        check_output("done_spurious_ts", ts_value, BAD_TS);
        check_output("done_spurious_done", done, 1'b1);

        // 6: reset during WAIT_TS, late data in IDLE dropped, then rerun
        apply_stimulus(0, 1, -1, GOOD_ID, GOOD_TS);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_output("t6_in_wait_ts", busy, 1'b1);
        reset = 1'b1;
        pend  = 1'b0;
        tick();
        check_output("t6_rst_busy", busy, 1'b0);
        check_output("t6_rst_done", done, 1'b0);
        check_output("t6_rst_ts", ts_value, 32'd0);
        tick();
        reset = 1'b0;
        apply_stimulus(0, 1, 1, GOOD_ID, GOOD_TS);
        avm_readdatavalid = 1'b1;
        avm_readdata      = JUNK;
        tick();
        check_output("t6_late_id", id_value, 32'd0);
        check_output("t6_late_ts", ts_value, 32'd0);
        run_to_done(1'b0, n);
        check_output("t6_latency", n, 4);
        check_output("t6_pass", pass, 1'b1);
        check_output("t6_id", id_value, GOOD_ID);
        check_output("t6_ts", ts_value, GOOD_TS);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
